multicycle_controller: RTL

Main control unit for the multicycle RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal. A Moore FSM sequences the shared ALU, memory, register file and PC across multiple cycles per instruction. It instantiates the existing aludec to produce ALUControl from the FSM's ALUOp. It also decodes ImmSrc from the opcode.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle main controller and the datapath.
//   op/funct3/funct7b5/Zero : instruction fields and ALU flag into the controller
//   ImmSrc..MemWrite        : datapath selects and write enables out of the controller
//   illegal/state_dbg       : observability of the sequencer
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, illegal, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// ALU operation decoder.
//   opb5/funct3/funct7b5 : instruction fields
//   alu_op               : 00 add, 01 subtract, 10 decode from funct fields
//   alu_control          : ALU operation select
module aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      default: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi may carry it in its immediate
          3'b000:  alu_control = (opb5 & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end
endmodule

// Main Moore controller of the multicycle RV32I subset core.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low; also masks all write enables while low
//   bus   : master side of multicycle_controller_if (instr fields in, controls out)
//
// state    | meaning
// FETCH    | read instr, IR <= mem[PC], PC <= PC+4
// DECODE   | read regs, OldPC+imm precomputed for branch/jump
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory at computed address
// MEMWB    | write loaded data to rd
// MEMWRITE | store rs2 to data memory
// EXECUTER | R-type ALU op
// EXECUTEI | I-type ALU op
// ALUWB    | write ALU result to rd
// JAL      | PC <= target, ALU forms OldPC+4 for rd
// BEQ      | compare; PC <= target when equal
// ERROR    | illegal opcode, parked until reset
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, illegal;
  logic [1:0] imm_src;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = HALT_ON_ILLEGAL ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ERROR: begin
        illegal = 1'b1;
        state_d = S_ERROR;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  aludec u_aludec (
    .opb5       (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .alu_op     (alu_op),
    .alu_control(bus.ALUControl)
  );

  // enables are masked during reset so an abandoned instruction cannot write
  assign bus.IRWrite   = reset & ir_write;
  assign bus.PCWrite   = reset & (pc_update | (branch & bus.Zero));
  assign bus.RegWrite  = reset & reg_write;
  assign bus.MemWrite  = reset & mem_write;
  assign bus.ImmSrc    = imm_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ResultSrc = result_src;
  assign bus.AdrSrc    = adr_src;
  assign bus.illegal   = illegal;
  assign bus.state_dbg = state_q;
endmodule
